// File: rtl/cluster_periph_arbiter_pkg.sv
// Shared constants, FSM state type and address decode for the cluster peripheral arbiter.
// Decode is pure combinational; no state lives in this package.
package cluster_periph_arbiter_pkg;

  localparam logic [31:0] PERIPH_BASE_ADDR = 32'h1020_0000;
  localparam int          PERIPH_SLOT_BITS = 10;
  localparam logic [31:0] PERIPH_ERR_RDATA = 32'hBADA_CCE5;
  localparam int          PERIPH_NB_SLOTS  = 10;

  localparam logic [3:0] SPER_EOC_ID         = 4'd0;
  localparam logic [3:0] SPER_TIMER_ID       = 4'd1;
  localparam logic [3:0] SPER_EVENT_U_ID     = 4'd2;
  localparam logic [3:0] SPER_ICACHE_CTRL_ID = 4'd4;
  localparam logic [3:0] SPER_DMA_ID         = 4'd5;
  localparam logic [3:0] SPER_EXT_ID         = 4'd6;
  localparam logic [3:0] SPER_HWPE_ID        = 4'd7;
  localparam logic [3:0] SPER_DECOMP_ID      = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RSP
  } periph_arb_state_e;

  typedef struct packed {
    logic       err;
    logic [3:0] slot;
  } periph_dec_t;

  function automatic periph_dec_t periph_decode(input logic [31:0] add);
    logic [31:0] off;
    periph_dec_t d;
    off    = add - PERIPH_BASE_ADDR;
    d.slot = off[PERIPH_SLOT_BITS+3:PERIPH_SLOT_BITS];
    d.err  = 1'b0;
    // Addresses below the base wrap to a huge offset, so one compare covers both ends.
    if (off >= 32'(PERIPH_NB_SLOTS << PERIPH_SLOT_BITS)) begin
      d.err = 1'b1;
    end else if (d.slot == SPER_DECOMP_ID) begin
      d.err = 1'b1;
    end else if (d.slot == SPER_EVENT_U_ID + 4'd1) begin
      d.slot = SPER_EVENT_U_ID;
    end
    if (d.err) begin
      d.slot = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/cluster_periph_arbiter_rr_arb.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping; zero latency.
// No backpressure; the caller owns the pointer register.
module cluster_periph_rr_arb #(
  parameter int NB_MST = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NB_MST-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  winner,
  output logic              valid
);

  int idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 1; i <= NB_MST; i++) begin
      idx = (int'(ptr) + i) % NB_MST;
      if (!valid && req[idx]) begin
        winner = IDX_W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cluster_periph_arbiter.sv
// Round-robin share of the peripheral slave bus, one transaction outstanding; read = 3 cycles min.
// Masters hold req until gnt; hung/unmapped slaves return an error so nobody stalls forever.
module cluster_periph_arbiter
  import cluster_periph_arbiter_pkg::*;
#(
  parameter int NB_MST  = 4,
  parameter int NB_SLV  = 10,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NB_MST-1:0]          mst_req_i,
  input  logic [NB_MST*ADDR_W-1:0]   mst_add_i,
  input  logic [NB_MST-1:0]          mst_wen_i,
  input  logic [NB_MST*DATA_W-1:0]   mst_wdata_i,
  input  logic [NB_MST*DATA_W/8-1:0] mst_be_i,
  output logic [NB_MST-1:0]          mst_gnt_o,
  output logic [NB_MST-1:0]          mst_r_valid_o,
  output logic [DATA_W-1:0]          mst_r_rdata_o,
  output logic                       mst_r_opc_o,
  output logic [NB_SLV-1:0]          slv_req_o,
  output logic [ADDR_W-1:0]          slv_add_o,
  output logic                       slv_wen_o,
  output logic [DATA_W-1:0]          slv_wdata_o,
  output logic [DATA_W/8-1:0]        slv_be_o,
  input  logic [NB_SLV-1:0]          slv_gnt_i,
  input  logic [NB_SLV-1:0]          slv_r_valid_i,
  input  logic [NB_SLV*DATA_W-1:0]   slv_r_rdata_i,
  input  logic [NB_SLV-1:0]          slv_r_opc_i,
  output logic                       busy_o
);

  localparam int MST_W = (NB_MST > 1) ? $clog2(NB_MST) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BE_W  = DATA_W / 8;

  periph_arb_state_e state_q;
  logic [MST_W-1:0]  ptr_q, win_q, arb_idx;
  logic              arb_vld;
  logic [ADDR_W-1:0] add_q, arb_add;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [NB_SLV-1:0] sel_q, dec_sel;
  logic              err_q, dec_err;
  periph_dec_t       dec;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rsp_rdata_q, sel_rdata;
  logic              rsp_opc_q, sel_opc;
  logic              gnt_hit, rvalid_hit, timeout_hit;

  cluster_periph_rr_arb #(
    .NB_MST (NB_MST),
    .IDX_W  (MST_W)
  ) i_rr_arb (
    .req    (mst_req_i),
    .ptr    (ptr_q),
    .winner (arb_idx),
    .valid  (arb_vld)
  );

  assign arb_add = mst_add_i[arb_idx*ADDR_W +: ADDR_W];

  always_comb begin
    dec     = periph_decode(32'(arb_add));
    dec_err = dec.err || (int'(dec.slot) >= NB_SLV);
    dec_sel = '0;
    if (!dec_err) begin
      dec_sel[dec.slot] = 1'b1;
    end
  end

  // sel_q is one-hot (or zero for the error slave), so OR-reduction acts as the response mux.
  always_comb begin
    sel_rdata = '0;
    sel_opc   = 1'b0;
    for (int s = 0; s < NB_SLV; s++) begin
      if (sel_q[s]) begin
        sel_rdata = sel_rdata | slv_r_rdata_i[s*DATA_W +: DATA_W];
        sel_opc   = sel_opc | slv_r_opc_i[s];
      end
    end
  end

  assign gnt_hit     = |(slv_gnt_i & sel_q);
  assign rvalid_hit  = |(slv_r_valid_i & sel_q);
  // cnt_q counts cycles since the slave grant, so the error fires TIMEOUT cycles after gnt.
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt_q) >= TIMEOUT - 1);

  assign busy_o        = (state_q != IDLE);
  assign mst_r_rdata_o = rsp_rdata_q;
  assign mst_r_opc_o   = rsp_opc_q;

  always_comb begin
    slv_req_o     = '0;
    slv_add_o     = '0;
    slv_wen_o     = 1'b0;
    slv_wdata_o   = '0;
    slv_be_o      = '0;
    mst_gnt_o     = '0;
    mst_r_valid_o = '0;
    if (state_q == REQ) begin
      slv_req_o = sel_q;
      if (!err_q) begin
        slv_add_o   = add_q;
        slv_wen_o   = wen_q;
        slv_wdata_o = wdata_q;
        slv_be_o    = be_q;
      end
      if (err_q || gnt_hit) begin
        mst_gnt_o[win_q] = 1'b1;
      end
    end
    if (state_q == RSP) begin
      mst_r_valid_o[win_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      add_q       <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      sel_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_opc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (arb_vld) begin
            ptr_q   <= arb_idx;
            win_q   <= arb_idx;
            add_q   <= arb_add;
            wen_q   <= mst_wen_i[arb_idx];
            wdata_q <= mst_wdata_i[arb_idx*DATA_W +: DATA_W];
            be_q    <= mst_be_i[arb_idx*BE_W +: BE_W];
            sel_q   <= dec_sel;
            err_q   <= dec_err;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (err_q) begin
            rsp_rdata_q <= PERIPH_ERR_RDATA;
            rsp_opc_q   <= 1'b1;
            state_q     <= RSP;
          end else if (gnt_hit) begin
            cnt_q   <= CNT_W'(1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (rvalid_hit) begin
            rsp_rdata_q <= wen_q ? sel_rdata : '0;
            rsp_opc_q   <= sel_opc;
            state_q     <= RSP;
          end else if (timeout_hit) begin
            rsp_rdata_q <= PERIPH_ERR_RDATA;
            rsp_opc_q   <= 1'b1;
            state_q     <= RSP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RSP: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_periph_arbiter.sv
// Directed bench: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_cluster_periph_arbiter;

  localparam int NM = 4;
  localparam int NS = 10;
  localparam int TO = 4;

  logic            clk_i  = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NM-1:0]   mst_req_i   = '0;
  logic [NM*32-1:0] mst_add_i  = '0;
  logic [NM-1:0]   mst_wen_i   = '0;
  logic [NM*32-1:0] mst_wdata_i = '0;
  logic [NM*4-1:0] mst_be_i    = '0;
  logic [NM-1:0]   mst_gnt_o, mst_r_valid_o;
  logic [31:0]     mst_r_rdata_o;
  logic            mst_r_opc_o;
  logic [NS-1:0]   slv_req_o;
  logic [31:0]     slv_add_o;
  logic            slv_wen_o;
  logic [31:0]     slv_wdata_o;
  logic [3:0]      slv_be_o;
  logic [NS-1:0]   slv_gnt_i, slv_r_valid_i, slv_r_opc_i;
  logic [NS*32-1:0] slv_r_rdata_i;
  logic            busy_o;

  logic [NS-1:0]   rv_model = '0;
  logic [NS-1:0]   rv_force = '0;
  logic [NS-1:0]   no_rsp   = '0;
  logic            hold_reqs = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int rv_cyc = 0;
  int rv_count = 0;

  typedef struct {
    int          mst;
    logic [9:0]  slv;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } gnt_exp_t;

  typedef struct {
    int          mst;
    logic [31:0] rdata;
    logic        opc;
  } rsp_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  gnt_exp_t ge;
  rsp_exp_t re;

  cluster_periph_arbiter #(
    .NB_MST (NM), .NB_SLV (NS), .ADDR_W (32), .DATA_W (32), .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mst_req_i     (mst_req_i),
    .mst_add_i     (mst_add_i),
    .mst_wen_i     (mst_wen_i),
    .mst_wdata_i   (mst_wdata_i),
    .mst_be_i      (mst_be_i),
    .mst_gnt_o     (mst_gnt_o),
    .mst_r_valid_o (mst_r_valid_o),
    .mst_r_rdata_o (mst_r_rdata_o),
    .mst_r_opc_o   (mst_r_opc_o),
    .slv_req_o     (slv_req_o),
    .slv_add_o     (slv_add_o),
    .slv_wen_o     (slv_wen_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_be_o      (slv_be_o),
    .slv_gnt_i     (slv_gnt_i),
    .slv_r_valid_i (slv_r_valid_i),
    .slv_r_rdata_i (slv_r_rdata_i),
    .slv_r_opc_i   (slv_r_opc_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Slave model: grants at once, answers the next cycle unless muted; slave s returns A00s_0000.
  assign slv_gnt_i     = slv_req_o;
  assign slv_r_valid_i = rv_model | rv_force;
  assign slv_r_opc_i   = 10'b10_0000_0000;
  for (genvar s = 0; s < NS; s++) begin : g_slv
    assign slv_r_rdata_i[s*32 +: 32] = 32'hA000_0000 | (32'(s) << 16);
  end
  always @(posedge clk_i) rv_model <= slv_req_o & slv_gnt_i & ~no_rsp;

  // Masters drop their request once granted.
  always @(negedge clk_i) if (!hold_reqs) mst_req_i = mst_req_i & ~mst_gnt_o;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mst_gnt_o != '0) begin
        gnt_cyc = cyc;
        if (gq.size() == 0) begin
          check("gnt_unexpected", 64'(mst_gnt_o), 64'd0);
        end else begin
          ge = gq.pop_front();
          check("gnt_mst", 64'(mst_gnt_o), 64'd1 << ge.mst);
          check("gnt_slv_req", 64'(slv_req_o), 64'(ge.slv));
          if (ge.slv != '0) begin
            check("slv_add", 64'(slv_add_o), 64'(ge.add));
            check("slv_wen", 64'(slv_wen_o), 64'(ge.wen));
            if (!ge.wen) begin
              check("slv_wdata", 64'(slv_wdata_o), 64'(ge.wdata));
              check("slv_be", 64'(slv_be_o), 64'(ge.be));
            end
          end
        end
      end
      if (mst_r_valid_o != '0) begin
        rv_cyc = cyc;
        rv_count++;
        if (rq.size() == 0) begin
          check("rsp_unexpected", 64'(mst_r_valid_o), 64'd0);
        end else begin
          re = rq.pop_front();
          check("rsp_mst", 64'(mst_r_valid_o), 64'd1 << re.mst);
          check("rsp_rdata", 64'(mst_r_rdata_o), 64'(re.rdata));
          check("rsp_opc", 64'(mst_r_opc_o), 64'(re.opc));
        end
      end
    end
  end

  task automatic issue(input int m, input logic [31:0] add, input logic wen,
                       input logic [31:0] wd, input logic [3:0] be);
    mst_add_i[m*32 +: 32]   = add;
    mst_wen_i[m]            = wen;
    mst_wdata_i[m*32 +: 32] = wd;
    mst_be_i[m*4 +: 4]      = be;
    mst_req_i[m]            = 1'b1;
  endtask

  task automatic expect_txn(input int m, input logic [9:0] slv, input logic [31:0] add,
                            input logic wen, input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] rd, input logic opc, input bit with_rsp);
    gnt_exp_t g;
    rsp_exp_t r;
    g = '{mst: m, slv: slv, add: add, wen: wen, wdata: wd, be: be};
    r = '{mst: m, rdata: rd, opc: opc};
    gq.push_back(g);
    if (with_rsp) rq.push_back(r);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 64'(n >= budget), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int cnt;
    logic [31:0] err_adds [3];
    err_adds[0] = 32'h1020_2000;
    err_adds[1] = 32'h1020_2800;
    err_adds[2] = 32'h1010_0000;

    repeat (2) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_gnt", 64'(mst_gnt_o), 64'd0);
    check("rst_rvalid", 64'(mst_r_valid_o), 64'd0);
    check("rst_slv_req", 64'(slv_req_o), 64'd0);
    check("rst_rdata", 64'(mst_r_rdata_o), 64'd0);
    check("rst_opc", 64'(mst_r_opc_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Pointer 0: master 2 wins over master 0, then master 0 is served.
    expect_txn(2, 10'b00_0000_0010, 32'h1020_0400, 1'b1, 0, 0, 32'hA001_0000, 1'b0, 1);
    expect_txn(0, 10'b00_0000_0010, 32'h1020_0400, 1'b1, 0, 0, 32'hA001_0000, 1'b0, 1);
    issue(0, 32'h1020_0400, 1'b1, 0, 4'hF);
    issue(2, 32'h1020_0400, 1'b1, 0, 4'hF);
    wait_done("drain_rr_pair", 40);

    // Slot 3 aliases to slave 2; slave 9 chatters r_valid with opc=1 and must be ignored.
    rv_force[9] = 1'b1;
    @(negedge clk_i);
    expect_txn(1, 10'b00_0000_0100, 32'h1020_0C00, 1'b1, 0, 0, 32'hA002_0000, 1'b0, 1);
    issue(1, 32'h1020_0C00, 1'b1, 0, 4'hF);
    t0 = cyc;
    wait_done("drain_slot3", 40);
    check("lat_read_gnt", 64'(gnt_cyc - t0), 64'd1);
    check("lat_read_rv", 64'(rv_cyc - t0), 64'd3);
    rv_force[9] = 1'b0;

    // Unused slot 8, end of window and below base all hit the error slave.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      expect_txn(0, 10'b0, err_adds[i], 1'b1, 0, 0, 32'hBADA_CCE5, 1'b1, 1);
      issue(0, err_adds[i], 1'b1, 0, 4'hF);
      t0 = cyc;
      wait_done("drain_err", 40);
      check("lat_err_gnt", 64'(gnt_cyc - t0), 64'd1);
      check("lat_err_rv", 64'(rv_cyc - t0), 64'd2);
    end

    // Write to slot 4 still gets a response, with rdata driven 0.
    @(negedge clk_i);
    expect_txn(3, 10'b00_0001_0000, 32'h1020_1000, 1'b0, 32'h1234_5678, 4'b0011, 32'h0, 1'b0, 1);
    issue(3, 32'h1020_1000, 1'b0, 32'h1234_5678, 4'b0011);
    wait_done("drain_write", 40);

    // Slave 6 grants but never answers: error 4 cycles after gnt, later stray r_valid ignored.
    no_rsp[6] = 1'b1;
    @(negedge clk_i);
    expect_txn(2, 10'b00_0100_0000, 32'h1020_1800, 1'b1, 0, 0, 32'hBADA_CCE5, 1'b1, 1);
    issue(2, 32'h1020_1800, 1'b1, 0, 4'hF);
    wait_done("drain_timeout", 40);
    check("timeout_gnt_to_rv", 64'(rv_cyc - gnt_cyc), 64'd4);
    cnt = rv_count;
    @(negedge clk_i);
    rv_force[6] = 1'b1;
    @(negedge clk_i);
    rv_force[6] = 1'b0;
    repeat (3) @(negedge clk_i);
    check("stray_rv_count", 64'(rv_count), 64'(cnt));
    check("stray_busy", 64'(busy_o), 64'd0);

    // Reset while in WAIT: outputs clear at once, the transaction is dropped.
    expect_txn(3, 10'b00_0100_0000, 32'h1020_1800, 1'b1, 0, 0, 0, 1'b0, 0);
    issue(3, 32'h1020_1800, 1'b1, 0, 4'hF);
    t0 = 0;
    while (gq.size() != 0 && t0 < 20) begin
      @(negedge clk_i);
      t0++;
    end
    check("rst_mid_gnt_seen", 64'(t0 >= 20), 64'd0);
    @(negedge clk_i);
    check("pre_rst_busy", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_slv_req", 64'(slv_req_o), 64'd0);
    check("arst_rvalid", 64'(mst_r_valid_o), 64'd0);
    check("arst_rdata", 64'(mst_r_rdata_o), 64'd0);
    check("arst_opc", 64'(mst_r_opc_o), 64'd0);
    no_rsp = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_busy", 64'(busy_o), 64'd0);
    expect_txn(0, 10'b00_0000_0001, 32'h1020_0000, 1'b1, 0, 0, 32'hA000_0000, 1'b0, 1);
    issue(0, 32'h1020_0000, 1'b1, 0, 4'hF);
    t0 = cyc;
    wait_done("drain_post_rst", 40);
    check("lat_post_rst_rv", 64'(rv_cyc - t0), 64'd3);

    // All masters request continuously from pointer 0: grants rotate 1,2,3,0,1,2,3,0.
    @(negedge clk_i);
    hold_reqs = 1'b1;
    for (int k = 0; k < 8; k++) begin
      expect_txn((k + 1) % 4, 10'b00_0010_0000, 32'h1020_1400, 1'b1, 0, 0,
                 32'hA005_0000, 1'b0, 1);
    end
    for (int m = 0; m < 4; m++) issue(m, 32'h1020_1400, 1'b1, 0, 4'hF);
    t0 = 0;
    while (gq.size() != 0 && t0 < 100) begin
      @(negedge clk_i);
      t0++;
    end
    mst_req_i = '0;
    hold_reqs = 1'b0;
    check("rotation_budget", 64'(t0 >= 100), 64'd0);
    wait_done("drain_rotation", 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cluster_periph_arbiter.md
Name: cluster_periph_arbiter

Overview:
- Shares the cluster peripheral slave bus between NB_MST requesters (cores, DMA, debug) with round-robin arbitration.
- Decodes the address into one of the 1 KiB peripheral slots starting at 0x1020_0000 and drives exactly one slave per transaction.
- Routes the registered response back to the winning requester.
- Handles unmapped/unused slots and hung slaves internally with an error response, so no requester can stall forever.

Parameters:
- NB_MST, 4, number of requesters.
- NB_SLV, 10, number of slave ports (slot IDs 0..9).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles waiting for a slave response before an error is returned; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mst_req_i  in  NB_MST  request per master
- mst_add_i  in  NB_MST*ADDR_W  address
- mst_wen_i  in  NB_MST  1 = read, 0 = write
- mst_wdata_i  in  NB_MST*DATA_W  write data
- mst_be_i  in  NB_MST*DATA_W/8  byte enables
- mst_gnt_o  out  NB_MST  grant, one-hot or zero
- mst_r_valid_o  out  NB_MST  response valid
- mst_r_rdata_o  out  DATA_W  shared read data
- mst_r_opc_o  out  1  response error flag
- slv_req_o  out  NB_SLV  one-hot slave request
- slv_add_o  out  ADDR_W  address to slaves
- slv_wen_o  out  1  read/write to slaves
- slv_wdata_o  out  DATA_W  write data to slaves
- slv_be_o  out  DATA_W/8  byte enables to slaves
- slv_gnt_i  in  NB_SLV  slave grant
- slv_r_valid_i  in  NB_SLV  slave response valid
- slv_r_rdata_i  in  NB_SLV*DATA_W  slave read data
- slv_r_opc_i  in  NB_SLV  slave error flag
- busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: all outputs 0; FSM = IDLE; round-robin pointer = 0; timeout counter = 0.
- Decode:
  - off = add - 0x1020_0000; slot = off[13:10].
  - slot 3 maps to 2 (event unit, dual slot).
  - slot 8 (decompressor, unused) and slot >= 10 go to the internal error slave.
  - Any add outside [0x1020_0000, 0x1020_2800) goes to the error slave.
- Arbitration:
  - Round-robin among asserted mst_req_i, starting from pointer+1 (mod NB_MST).
  - The pointer updates to the winner at acceptance.
  - Requests are evaluated only in IDLE.
- FSM states:
  - IDLE:
    - With any request: latch winner index, add, wen, wdata, be and decoded slot; go to REQ.
    - No mst_gnt_o is issued in IDLE.
  - REQ (mapped slot):
    - slv_req_o[slot] = 1; slave-bus fields driven from the latched request.
    - On slv_gnt_i[slot]: mst_gnt_o[winner] = 1 for exactly this cycle; go to WAIT.
    - The master must hold its request until granted.
  - REQ (error slot): mst_gnt_o[winner] = 1 in the first REQ cycle; no slave request; go to RSP with opc=1, rdata=0xBADA_CCE5.
  - WAIT:
    - Timeout counter increments each cycle.
    - On slv_r_valid_i[slot]: register rdata/opc; go to RSP.
    - If TIMEOUT != 0 and counter reaches TIMEOUT: register opc=1, rdata=0xBADA_CCE5; go to RSP. A later stray r_valid from that slave is ignored.
  - RSP: mst_r_valid_o[winner] = 1 for one cycle with the registered rdata/opc; return to IDLE; counter cleared.
- Latency, mapped read with immediate slave gnt and r_valid in the cycle after gnt:
  - gnt at cycle 1 after IDLE acceptance.
  - r_valid at master at cycle 3.
- Single outstanding transaction.
- New requests arriving during a transaction wait; the next transaction can be accepted in the cycle after RSP.
- Responses for writes are also returned (r_valid pulse; rdata undefined, driven 0).
- Simultaneous slv_r_valid_i from a non-selected slave is ignored.
- mst_r_rdata_o/mst_r_opc_o hold their last value when r_valid is 0.
- Asynchronous reset mid-transaction:
  - FSM returns to IDLE; all outputs 0 immediately.
  - The pending transaction is dropped with no response.

Decomposition:
- Shared package (extends the cluster package): PERIPH_BASE_ADDR = 32'h1020_0000, PERIPH_SLOT_BITS = 10, PERIPH_ERR_RDATA = 32'hBADA_CCE5, periph_arb_state_e {IDLE, REQ, WAIT, RSP}; reuse the existing SPER_* ID constants for decode.
- Sub-module cluster_periph_rr_arb: parameter NB_MST; inputs req vector, pointer; outputs winner index and valid (combinational, with the pointer register kept in the parent).

Test Plan:
- Masters 0 and 2 both request a read of 0x1020_0400 at cycle 0 with the pointer at 0 -> master 2 is granted first (first asserted index after 0, scanning from pointer+1); slv_req_o = 10'b0000000010; master 0 is served next.
- Master 1 reads 0x1020_0C00 (slot 3) -> slv_req_o[2] = 1; the response from slave 2 is forwarded with opc = 0.
- Master 0 reads 0x1020_2000 (slot 8) -> no slave request; gnt at cycle 1, r_valid at cycle 2, rdata = 0xBADA_CCE5, opc = 1.
- TIMEOUT = 4; slave 6 grants but never responds -> mst_r_valid_o with opc = 1 four cycles after gnt; a later slv_r_valid_i[6] is ignored.
- All 4 masters request continuously for 8 transactions -> grants rotate 1, 2, 3, 0, 1, 2, 3, 0; none is starved.
- rst_ni asserted low during WAIT -> outputs 0 in the same cycle; after release, busy_o = 0 and a fresh request completes normally.
